// File: rtl/integral_image_builder_pkg.sv
// Shared types and defaults for the integral-image / rectangle-sum path.
// Optional squared-integral build is selected with IIMG_SQSUM_EN.
package haar_pkg;
    localparam int DEF_IMG_WIDTH  = 20;
    localparam int DEF_IMG_HEIGHT = 20;
    localparam int DEF_PIX_W      = 8;
    localparam int QUERY_LAT      = 6;

    typedef enum logic [1:0] {IDLE, FILL, DONE, QUERY} fill_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
    } rect_t;

    // Width that holds a full-window sum of values that are val_w bits wide.
    function automatic int sum_w(input int val_w, input int w, input int h);
        return val_w + $clog2(w * h);
    endfunction

    localparam int DEF_SUM_W = sum_w(DEF_PIX_W, DEF_IMG_WIDTH, DEF_IMG_HEIGHT);
    localparam int DEF_SQ_W  = sum_w(2 * DEF_PIX_W, DEF_IMG_WIDTH, DEF_IMG_HEIGHT);
endpackage

// File: rtl/integral_image_builder_if.sv
// Pixel stream, rectangle query and response bundle of integral_image_builder.
// r_sqsum exists only when IIMG_SQSUM_EN is defined.
interface integral_image_builder_if #(
    parameter int PIX_W = haar_pkg::DEF_PIX_W,
    parameter int SUM_W = haar_pkg::DEF_SUM_W,
    parameter int SQ_W  = haar_pkg::DEF_SQ_W
);
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_data;
    logic             img_ready;
    logic             q_valid;
    logic             q_ready;
    logic [7:0]       q_x;
    logic [7:0]       q_y;
    logic [7:0]       q_w;
    logic [7:0]       q_h;
    logic             r_valid;
    logic [SUM_W-1:0] r_sum;
    logic             r_err;
`ifdef IIMG_SQSUM_EN
    logic [SQ_W-1:0]  r_sqsum;
`endif

    modport master (
        output pix_valid, pix_sof, pix_data, q_valid, q_x, q_y, q_w, q_h,
        input  pix_ready, img_ready, q_ready, r_valid, r_sum, r_err
`ifdef IIMG_SQSUM_EN
        , input r_sqsum
`endif
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, q_valid, q_x, q_y, q_w, q_h,
        output pix_ready, img_ready, q_ready, r_valid, r_sum, r_err
`ifdef IIMG_SQSUM_EN
        , output r_sqsum
`endif
    );
endinterface

// File: rtl/integral_image_builder_iimg_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read.
module iimg_ram #(
    parameter int DEPTH = 400,
    parameter int DW    = 17,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/integral_image_builder.sv
// Builds the integral image of one raster window and answers rectangle-sum queries
// with fixed latency. Define IIMG_SQSUM_EN to also build a squared integral (r_sqsum).
module integral_image_builder
    import haar_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_W      = DEF_PIX_W
) (
    input logic clk,
    input logic reset,
    integral_image_builder_if.slave bus
);
    localparam int SUM_W = sum_w(PIX_W, IMG_WIDTH, IMG_HEIGHT);
    localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
`ifdef IIMG_SQSUM_EN
    localparam int SQ_W  = sum_w(2 * PIX_W, IMG_WIDTH, IMG_HEIGHT);
`endif

    fill_state_t                   state_q, state_d;
    logic [XW-1:0]                 x_q, x_d;
    logic [YW-1:0]                 y_q, y_d;
    logic [SUM_W-1:0]              row_acc_q, row_acc_d;
    logic [IMG_WIDTH-1:0][SUM_W-1:0] prev_row_q, prev_row_d;
    logic                          img_ready_q, img_ready_d;
    logic [2:0]                    qcnt_q, qcnt_d;
    logic                          q_ok_q, q_ok_d;
    logic [3:0][AW-1:0]            corner_addr_q, corner_addr_d;
    logic [3:0]                    corner_zero_q, corner_zero_d;
    logic [SUM_W-1:0]              acc_q, acc_d;
    logic                          r_valid_q, r_valid_d;
    logic [SUM_W-1:0]              r_sum_q, r_sum_d;
    logic                          r_err_q, r_err_d;
`ifdef IIMG_SQSUM_EN
    logic [SQ_W-1:0]               row_sq_q, row_sq_d;
    logic [IMG_WIDTH-1:0][SQ_W-1:0] prev_sq_q, prev_sq_d;
    logic [SQ_W-1:0]               acc_sq_q, acc_sq_d;
    logic [SQ_W-1:0]               r_sqsum_q, r_sqsum_d;
    logic [SQ_W-1:0]               wr_sq, rd_sq, row_sq, ii_sq, term_sq;
`endif

    logic             pix_acc, q_acc, pix_fill;
    logic             wr_en, rd_en, use_rd;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [SUM_W-1:0] wr_sum, rd_sum, row_sum, ii_sum, term;
    logic [XW-1:0]    col;
    logic [YW-1:0]    row;
    logic [8:0]       ex, ey, r0, r1, c0, c1;
    logic [2:0]       qm1;
    logic [1:0]       j;
    rect_t            rect;

    function automatic logic [AW-1:0] cell_addr(input logic [8:0] r, input logic [8:0] c);
        return AW'(int'(r) * IMG_WIDTH + int'(c));
    endfunction

    assign rect      = '{x: bus.q_x, y: bus.q_y, w: bus.q_w, h: bus.q_h};
    assign pix_acc   = bus.pix_valid && bus.pix_ready;
    assign q_acc     = bus.q_valid && bus.q_ready;
    // Only sof pixels start a window; other pixels outside FILL are dropped.
    assign pix_fill  = pix_acc && (bus.pix_sof || state_q == FILL);

    assign bus.pix_ready = (state_q != QUERY);
    assign bus.q_ready   = (state_q == DONE) && !(bus.pix_valid && bus.pix_sof);
    assign bus.img_ready = img_ready_q;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_sum     = r_sum_q;
    assign bus.r_err     = r_err_q;
`ifdef IIMG_SQSUM_EN
    assign bus.r_sqsum   = r_sqsum_q;
`endif

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        row_acc_d     = row_acc_q;
        prev_row_d    = prev_row_q;
        img_ready_d   = img_ready_q;
        qcnt_d        = qcnt_q;
        q_ok_d        = q_ok_q;
        corner_addr_d = corner_addr_q;
        corner_zero_d = corner_zero_q;
        acc_d         = acc_q;
        r_valid_d     = 1'b0;
        r_sum_d       = r_sum_q;
        r_err_d       = r_err_q;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_sum        = '0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        col           = '0;
        row           = '0;
        row_sum       = '0;
        ii_sum        = '0;
        term          = '0;
        use_rd        = 1'b0;
        ex            = '0;
        ey            = '0;
        r0            = '0;
        r1            = '0;
        c0            = '0;
        c1            = '0;
        qm1           = '0;
        j             = '0;
`ifdef IIMG_SQSUM_EN
        row_sq_d      = row_sq_q;
        prev_sq_d     = prev_sq_q;
        acc_sq_d      = acc_sq_q;
        r_sqsum_d     = r_sqsum_q;
        wr_sq         = '0;
        row_sq        = '0;
        ii_sq         = '0;
        term_sq       = '0;
`endif

        if (pix_fill) begin
            col     = bus.pix_sof ? '0 : x_q;
            row     = bus.pix_sof ? '0 : y_q;
            row_sum = (bus.pix_sof ? '0 : row_acc_q) + SUM_W'(bus.pix_data);
            ii_sum  = (row == '0 ? '0 : prev_row_q[col]) + row_sum;
            wr_en   = 1'b1;
            wr_addr = AW'(int'(row) * IMG_WIDTH + int'(col));
            wr_sum  = ii_sum;
            prev_row_d[col] = ii_sum;
`ifdef IIMG_SQSUM_EN
            row_sq  = (bus.pix_sof ? '0 : row_sq_q)
                    + SQ_W'(bus.pix_data) * SQ_W'(bus.pix_data);
            ii_sq   = (row == '0 ? '0 : prev_sq_q[col]) + row_sq;
            wr_sq   = ii_sq;
            prev_sq_d[col] = ii_sq;
            row_sq_d = row_sq;
`endif
            state_d     = FILL;
            img_ready_d = 1'b0;
            row_acc_d   = row_sum;
            x_d         = col + 1'b1;
            y_d         = row;
            if (col == XW'(IMG_WIDTH - 1)) begin
                row_acc_d = '0;
`ifdef IIMG_SQSUM_EN
                row_sq_d  = '0;
`endif
                x_d       = '0;
                y_d       = row + 1'b1;
                if (row == YW'(IMG_HEIGHT - 1)) begin
                    y_d         = '0;
                    state_d     = DONE;
                    img_ready_d = 1'b1;
                end
            end
        end

        case (state_q)
            DONE: begin
                if (q_acc) begin
                    ex = {1'b0, rect.x} + {1'b0, rect.w};
                    ey = {1'b0, rect.y} + {1'b0, rect.h};
                    r0 = {1'b0, rect.y} - 9'd1;
                    c0 = {1'b0, rect.x} - 9'd1;
                    r1 = ey - 9'd1;
                    c1 = ex - 9'd1;
                    q_ok_d = (rect.w != '0) && (rect.h != '0)
                          && (ex <= 9'(IMG_WIDTH)) && (ey <= 9'(IMG_HEIGHT));
                    // Corner order A, B, C, D; signs +, -, -, +.
                    corner_addr_d = {cell_addr(r1, c1), cell_addr(r1, c0),
                                     cell_addr(r0, c1), cell_addr(r0, c0)};
                    corner_zero_d = {1'b0, rect.x == '0,
                                     rect.y == '0, rect.x == '0 || rect.y == '0};
                    qcnt_d  = '0;
                    acc_d   = '0;
`ifdef IIMG_SQSUM_EN
                    acc_sq_d = '0;
`endif
                    state_d = QUERY;
                end
            end
            QUERY: begin
                qcnt_d = qcnt_q + 3'd1;
                if (qcnt_q < 3'd4) begin
                    rd_en   = q_ok_q && !corner_zero_q[qcnt_q[1:0]];
                    rd_addr = corner_addr_q[qcnt_q[1:0]];
                end
                // Read data for corner j lands one cycle after its read slot.
                if (qcnt_q >= 3'd1 && qcnt_q <= 3'd4) begin
                    qm1    = qcnt_q - 3'd1;
                    j      = qm1[1:0];
                    use_rd = q_ok_q && !corner_zero_q[j];
                    term   = use_rd ? rd_sum : '0;
                    acc_d  = (j == 2'd0 || j == 2'd3) ? acc_q + term : acc_q - term;
`ifdef IIMG_SQSUM_EN
                    term_sq  = use_rd ? rd_sq : '0;
                    acc_sq_d = (j == 2'd0 || j == 2'd3) ? acc_sq_q + term_sq
                                                        : acc_sq_q - term_sq;
`endif
                end
                if (qcnt_q == 3'(QUERY_LAT - 1)) begin
                    r_valid_d = 1'b1;
                    r_sum_d   = q_ok_q ? acc_q : '0;
                    r_err_d   = !q_ok_q;
`ifdef IIMG_SQSUM_EN
                    r_sqsum_d = q_ok_q ? acc_sq_q : '0;
`endif
                    state_d   = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            row_acc_q     <= '0;
            prev_row_q    <= '0;
            img_ready_q   <= 1'b0;
            qcnt_q        <= '0;
            q_ok_q        <= 1'b0;
            corner_addr_q <= '0;
            corner_zero_q <= '0;
            acc_q         <= '0;
            r_valid_q     <= 1'b0;
            r_sum_q       <= '0;
            r_err_q       <= 1'b0;
`ifdef IIMG_SQSUM_EN
            row_sq_q      <= '0;
            prev_sq_q     <= '0;
            acc_sq_q      <= '0;
            r_sqsum_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_acc_q     <= row_acc_d;
            prev_row_q    <= prev_row_d;
            img_ready_q   <= img_ready_d;
            qcnt_q        <= qcnt_d;
            q_ok_q        <= q_ok_d;
            corner_addr_q <= corner_addr_d;
            corner_zero_q <= corner_zero_d;
            acc_q         <= acc_d;
            r_valid_q     <= r_valid_d;
            r_sum_q       <= r_sum_d;
            r_err_q       <= r_err_d;
`ifdef IIMG_SQSUM_EN
            row_sq_q      <= row_sq_d;
            prev_sq_q     <= prev_sq_d;
            acc_sq_q      <= acc_sq_d;
            r_sqsum_q     <= r_sqsum_d;
`endif
        end
    end

    iimg_ram #(.DEPTH(DEPTH), .DW(SUM_W), .AW(AW)) u_sum_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_sum),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_sum)
    );

`ifdef IIMG_SQSUM_EN
    iimg_ram #(.DEPTH(DEPTH), .DW(SQ_W), .AW(AW)) u_sq_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_sq),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_sq)
    );
`endif
endmodule
